// File: rtl/ahb_pkg.sv
// Shared AHB encodings and arbiter constants used by the arbiter and its selector.
package ahb_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'b000,
    HB_INCR   = 3'b001,
    HB_INCR4  = 3'b011
  } hburst_e;

  typedef enum logic [1:0] {
    ARB    = 2'b00,
    BURST  = 2'b01,
    LOCKED = 2'b10
  } arb_state_e;

  localparam int unsigned INCR4_BEATS = 4;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first requester after ptr, wrapping modulo NUM_REQ.
module rr_select #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    // Offsets 1..NUM_REQ visit ptr+1 first and ptr itself last.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!valid && req[i] && (i == ((32'(ptr) + k) % NUM_REQ))) begin
          winner[i] = 1'b1;
          valid     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter: registered one-hot grant, address-phase owner index and lock flag.
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned DEFAULT_MASTER = 0,
  parameter int unsigned MIDX_W         = 3
) (
  input  logic                   CLK_ARBITER,
  input  logic                   RESET_ARBITER,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MIDX_W-1:0]      HMASTER,
  output logic                   HMASTLOCK
);

  localparam logic [NUM_MASTERS-1:0] DEFAULT_OH  = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [MIDX_W-1:0]      DEFAULT_IDX = MIDX_W'(DEFAULT_MASTER);

  arb_state_e state, state_nxt;
  logic [1:0]             beat_cnt, beat_nxt;
  logic [MIDX_W-1:0]      rr_ptr, ptr_nxt;
  logic [NUM_MASTERS-1:0] grant_nxt;
  logic [MIDX_W-1:0]      master_nxt;
  logic                   mlock_nxt;

  logic [NUM_MASTERS-1:0] win_oh, sel_oh;
  logic                   win_valid;
  logic [MIDX_W-1:0]      owner_idx, sel_idx;
  logic                   owner_lock, owner_req;
  logic                   is_idle, is_busy, is_nonseq, is_seq;
  logic                   is_single, is_incr4, is_incr;
  logic                   incr_hold, handover;

  rr_select #(
    .NUM_REQ (NUM_MASTERS),
    .PTR_W   (MIDX_W)
  ) u_rr_select (
    .req    (HBUSREQ),
    .ptr    (rr_ptr),
    .winner (win_oh),
    .valid  (win_valid)
  );

  assign sel_oh = win_valid ? win_oh : DEFAULT_OH;

  // HGRANT is one-hot, so masking avoids indexing by a wider index.
  assign owner_lock = |(HLOCK & HGRANT);
  assign owner_req  = |(HBUSREQ & HGRANT);

  assign is_idle   = (HTRANS == HT_IDLE);
  assign is_busy   = (HTRANS == HT_BUSY);
  assign is_nonseq = (HTRANS == HT_NONSEQ);
  assign is_seq    = (HTRANS == HT_SEQ);
  assign is_single = (HBURST == HB_SINGLE);
  assign is_incr4  = (HBURST == HB_INCR4);
  assign is_incr   = !is_single && !is_incr4;

  always_comb begin
    owner_idx = '0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (HGRANT[i]) owner_idx = MIDX_W'(i);
      if (sel_oh[i]) sel_idx   = MIDX_W'(i);
    end
  end

  // Grant may only move in ARB, outside a lock, and never on the edge that opens
  // an INCR4 burst or while an undefined-length burst is still streaming.
  assign incr_hold = is_incr && owner_req && (is_seq || is_busy);
  assign handover  = (state == ARB) && !owner_lock && !(is_nonseq && is_incr4) && !incr_hold;

  always_comb begin
    state_nxt  = state;
    beat_nxt   = beat_cnt;
    ptr_nxt    = rr_ptr;
    grant_nxt  = HGRANT;
    master_nxt = HMASTER;
    mlock_nxt  = HMASTLOCK;
    if (HREADY) begin
      master_nxt = owner_idx;
      mlock_nxt  = owner_lock;
      case (state)
        ARB: begin
          if (is_nonseq && is_incr4) begin
            state_nxt = BURST;
            beat_nxt  = 2'(INCR4_BEATS - 1);
          end else if (is_nonseq && is_single) begin
            state_nxt = ARB;
          end else if (owner_lock && !is_idle) begin
            state_nxt = LOCKED;
          end
        end
        BURST: begin
          if (is_seq) begin
            if (beat_cnt <= 2'd1) begin
              state_nxt = ARB;
              beat_nxt  = '0;
            end else begin
              beat_nxt = beat_cnt - 2'd1;
            end
          end else if (!is_busy) begin
            state_nxt = ARB;
            beat_nxt  = '0;
          end
        end
        LOCKED: begin
          if (!owner_lock && is_idle) state_nxt = ARB;
        end
        default: begin
          state_nxt = ARB;
          beat_nxt  = '0;
        end
      endcase
      if (handover) begin
        grant_nxt = sel_oh;
        ptr_nxt   = sel_idx;
      end
    end
  end

  always_ff @(posedge CLK_ARBITER) begin
    if (RESET_ARBITER) begin
      state     <= ARB;
      beat_cnt  <= '0;
      rr_ptr    <= DEFAULT_IDX;
      HGRANT    <= DEFAULT_OH;
      HMASTER   <= DEFAULT_IDX;
      HMASTLOCK <= 1'b0;
    end else begin
      state     <= state_nxt;
      beat_cnt  <= beat_nxt;
      rr_ptr    <= ptr_nxt;
      HGRANT    <= grant_nxt;
      HMASTER   <= master_nxt;
      HMASTLOCK <= mlock_nxt;
    end
  end

endmodule
